// File: rtl/rv32m_pkg.sv
// rtl/rv32m_pkg.sv - shared types and constants for the RV32M multiply/divide unit
package rv32m_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_DIVIDEND  = 32'h8000_0000;
  localparam logic [31:0] OVF_DIVISOR   = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUOT      = 32'h8000_0000;
  localparam logic [31:0] OVF_REM       = 32'h0000_0000;

endpackage

// File: rtl/add_sub_32bit.sv
// rtl/add_sub_32bit.sv - 32-bit adder/subtractor used for operand and result negation
module add_sub_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] y
);

  // y = a - b when sub is set, otherwise a + b
  always_comb begin
    y = sub ? (a - b) : (a + b);
  end

endmodule

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - iterative shift-add multiplier / restoring divider datapath
module muldiv_core #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              div,
  input  logic [XLEN-1:0]   mag_a,
  input  logic [XLEN-1:0]   mag_b,
  output logic [2*XLEN-1:0] acc,
  output logic              last
);

  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   opnd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              div_q;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     rem_shift;
  logic [XLEN+1:0]   trial;

  // One iteration: multiply adds the multiplicand into the high half and shifts right;
  // divide shifts the remainder left and keeps the trial difference when it does not borrow.
  always_comb begin
    add_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    rem_shift = acc_q[2*XLEN-1:XLEN-1];
    trial     = {1'b0, rem_shift} - {2'b00, opnd_q};
    if (div_q) begin
      if (!trial[XLEN+1]) acc_next = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                acc_next = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else if (acc_q[0]) begin
      acc_next = {add_sum, acc_q[XLEN-1:1]};
    end else begin
      acc_next = {1'b0, acc_q[2*XLEN-1:1]};
    end
  end

  // Load operands on accept, then advance one iteration per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else if (load) begin
      acc_q  <= {{XLEN{1'b0}}, (div ? mag_a : mag_b)};
      opnd_q <= div ? mag_b : mag_a;
      cnt_q  <= '0;
      div_q  <= div;
    end else if (step) begin
      acc_q  <= acc_next;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign acc  = acc_q;
  assign last = (cnt_q == CNT_W'(XLEN - 1));

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle RV32M execute unit: FSM, sign handling, result mux
module muldiv_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_in, op_q;
  logic              neg_in, neg_q, fast_in, fast_q;
  logic              signed_a, signed_b, div_zero, overflow;
  logic              accept, result_valid, core_last;
  logic [XLEN-1:0]   fast_val_in, fast_val_q, result_q;
  logic [XLEN-1:0]   neg_a, neg_b, mag_a, mag_b;
  logic [XLEN-1:0]   raw, fix_a, fix_b, fix_y, calc_result;
  logic              fix_sub;
  logic [2*XLEN-1:0] acc;

  assign accept = (state_q == IDLE) && i_valid && !i_flush;

  add_sub_32bit u_neg_a (.a('0), .b(i_op_a), .sub(1'b1), .y(neg_a));
  add_sub_32bit u_neg_b (.a('0), .b(i_op_b), .sub(1'b1), .y(neg_b));
  add_sub_32bit u_fix   (.a(fix_a), .b(fix_b), .sub(fix_sub), .y(fix_y));

  // Decode the incoming request: operand signedness, result sign, fast-path cases
  always_comb begin
    op_in    = muldiv_op_e'(i_op);
    signed_a = 1'b0;
    signed_b = 1'b0;
    neg_in   = 1'b0;
    case (op_in)
      OP_MULH, OP_DIV: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
        neg_in   = i_op_a[XLEN-1] ^ i_op_b[XLEN-1];
      end
      OP_MULHSU: begin
        signed_a = 1'b1;
        neg_in   = i_op_a[XLEN-1];
      end
      OP_REM: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
        neg_in   = i_op_a[XLEN-1];
      end
      default: ;
    endcase
    mag_a    = (signed_a && i_op_a[XLEN-1]) ? neg_a : i_op_a;
    mag_b    = (signed_b && i_op_b[XLEN-1]) ? neg_b : i_op_b;
    div_zero = i_op[2] && (i_op_b == '0);
    overflow = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (i_op_a == OVF_DIVIDEND) && (i_op_b == OVF_DIVISOR);
    fast_in  = div_zero || overflow;
    if (div_zero) fast_val_in = i_op[1] ? i_op_a : DIV_ZERO_QUOT;
    else          fast_val_in = i_op[1] ? OVF_REM : OVF_QUOT;
  end

  muldiv_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .load  (accept && !fast_in),
    .step  (state_q == CALC),
    .div   (i_op[2]),
    .mag_a (mag_a),
    .mag_b (mag_b),
    .acc   (acc),
    .last  (core_last)
  );

  // Pick the result half and apply the sign; a 64-bit product negates its high half
  // as ~hi plus the borrow that comes out of a zero low half
  always_comb begin
    case (op_q)
      OP_MUL, OP_DIV, OP_DIVU: raw = acc[XLEN-1:0];
      default:                 raw = acc[2*XLEN-1:XLEN];
    endcase
    fix_a   = raw;
    fix_b   = '0;
    fix_sub = 1'b0;
    if (neg_q) begin
      if ((op_q == OP_MULH) || (op_q == OP_MULHSU)) begin
        fix_a = ~raw;
        fix_b = {{(XLEN-1){1'b0}}, (acc[XLEN-1:0] == '0)};
      end else begin
        fix_a   = '0;
        fix_b   = raw;
        fix_sub = 1'b1;
      end
    end
    calc_result = fast_q ? fast_val_q : fix_y;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and handshake outputs; flush drops any in-flight op without a pulse
  always_comb begin
    state_d      = state_q;
    result_valid = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = fast_in ? DONE : CALC;
      CALC: begin
        if (i_flush)        state_d = IDLE;
        else if (core_last) state_d = DONE;
      end
      DONE: begin
        state_d      = IDLE;
        result_valid = !i_flush;
      end
      default: state_d = IDLE;
    endcase
    o_ready  = (state_q == IDLE);
    o_busy   = (state_q != IDLE);
    o_valid  = result_valid;
    o_result = result_valid ? calc_result : result_q;
  end

  // Latch request attributes on accept and keep the last delivered result
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q       <= OP_MUL;
      neg_q      <= 1'b0;
      fast_q     <= 1'b0;
      fast_val_q <= '0;
      result_q   <= '0;
    end else begin
      if (accept) begin
        op_q       <= op_in;
        neg_q      <= neg_in;
        fast_q     <= fast_in;
        fast_val_q <= fast_val_in;
      end
      if (result_valid) result_q <= calc_result;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        i_clk, i_rst_n, i_valid, i_flush;
  logic [2:0]  i_op;
  logic [31:0] i_op_a, i_op_b;
  logic        o_ready, o_busy, o_valid;
  logic [31:0] o_result;

  int checks = 0;
  int failures = 0;
  int n_valid = 0;
  logic [31:0] last_valid_res = '0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  muldiv_unit dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .i_op     (i_op),
    .i_op_a   (i_op_a),
    .i_op_b   (i_op_b),
    .i_flush  (i_flush),
    .o_ready  (o_ready),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_result (o_result)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      n_valid = n_valid + 1;
      last_valid_res = o_result;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        ua, ub, up;
    logic signed [31:0] sa32, sb32;
    logic               ovf;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa32 = a;
    sb32 = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'b000: begin sp = sa * sb; return sp[31:0]; end
      3'b001: begin sp = sa * sb; return sp[63:32]; end
      3'b010: begin sp = sa * $signed(ub); return sp[63:32]; end
      3'b011: begin up = ua * ub; return up[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return sa32 / sb32;
      end
      3'b101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return sa32 % sb32;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0)) return 1;
    if (op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  task automatic wait_ready();
    int w = 0;
    while (o_ready !== 1'b1 && w < 100) begin
      @(posedge i_clk); #1;
      w++;
    end
    if (w >= 100) check("ready_timeout", {31'b0, o_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    wait_ready();
    i_op = op; i_op_a = a; i_op_b = b; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    lat = 1;
    while (o_valid !== 1'b1 && lat < 100) begin
      @(posedge i_clk); #1;
      lat++;
    end
    res = o_result;
  endtask

  task automatic do_vec(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat_exp);
    logic [31:0] res;
    int lat;
    run_op(op, a, b, res, lat);
    check({name, "_res"}, res, exp);
    check({name, "_lat"}, 32'(lat), 32'(lat_exp));
    @(posedge i_clk); #1;
    check({name, "_hold"}, o_result, exp);
  endtask

  initial begin
    logic [31:0] res, prev, a, b;
    logic [2:0]  op;
    int lat, nv0, sel;

    i_rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0;
    i_op = 3'b0; i_op_a = '0; i_op_b = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_ready",  {31'b0, o_ready}, 32'd1);
    check("rst_busy",   {31'b0, o_busy},  32'd0);
    check("rst_valid",  {31'b0, o_valid}, 32'd0);
    check("rst_result", o_result,         32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    vecs.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    vecs.push_back('{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33});
    vecs.push_back('{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    vecs.push_back('{3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33});
    vecs.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33});
    vecs.push_back('{3'b101, 32'd100,        32'd7,         32'd14,        33});
    vecs.push_back('{3'b111, 32'd100,        32'd7,         32'd2,         33});
    vecs.push_back('{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{3'b110, 32'd5,          32'd0,         32'd5,         1});
    vecs.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});
    vecs.push_back('{3'b001, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h3FFF_FFFF, 33});
    vecs.push_back('{3'b100, 32'h8000_0000,  32'd1,         32'h8000_0000, 33});
    vecs.push_back('{3'b101, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33});
    vecs.push_back('{3'b111, 32'd7,          32'd0,         32'd7,         1});
    vecs.push_back('{3'b000, 32'd0,          32'd12345,     32'd0,         33});

    foreach (vecs[i]) begin
      do_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    for (int i = 0; i < 60; i++) begin
      op  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
      if (sel == 3) begin a[31] = 1'b1; b = $urandom_range(1, 1000); end
      run_op(op, a, b, res, lat);
      check($sformatf("rand%0d_op%0d_res", i, op), res, ref_model(op, a, b));
      check($sformatf("rand%0d_op%0d_lat", i, op), 32'(lat), 32'(exp_lat(op, a, b)));
    end

    // flush has priority over a request in IDLE
    wait_ready();
    i_valid = 1'b1; i_flush = 1'b1; i_op = 3'b000; i_op_a = 32'd2; i_op_b = 32'd3;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    check("idle_flush_ready", {31'b0, o_ready}, 32'd1);

    // flush in the tenth CALC cycle, then an immediate MUL 3*4
    prev = o_result;
    nv0  = n_valid;
    i_op = 3'b100; i_op_a = 32'd1000; i_op_b = 32'd7; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (9) @(posedge i_clk);
    #1;
    check("flush_busy", {31'b0, o_busy}, 32'd1);
    i_flush = 1'b1;
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    check("flush_ready", {31'b0, o_ready}, 32'd1);
    check("flush_result_kept", o_result, prev);
    check("flush_no_valid", 32'(n_valid), 32'(nv0));
    run_op(3'b000, 32'd3, 32'd4, res, lat);
    check("after_flush_res", res, 32'd12);
    check("after_flush_lat", 32'(lat), 32'd33);
    @(posedge i_clk); #1;
    check("after_flush_one_pulse", 32'(n_valid), 32'(nv0 + 1));

    // reset in the twentieth CALC cycle
    nv0 = n_valid;
    i_op = 3'b011; i_op_a = $urandom; i_op_b = $urandom; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (19) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("midrst_ready",  {31'b0, o_ready}, 32'd1);
    check("midrst_busy",   {31'b0, o_busy},  32'd0);
    check("midrst_valid",  {31'b0, o_valid}, 32'd0);
    check("midrst_result", o_result,         32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    repeat (40) @(posedge i_clk);
    #1;
    check("midrst_no_valid", 32'(n_valid), 32'(nv0));
    do_vec("post_rst_div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);

    // i_valid held high across busy: one result per accept
    wait_ready();
    nv0 = n_valid;
    i_op = 3'b101; i_op_a = 32'd100; i_op_b = 32'd7; i_valid = 1'b1;
    repeat (60) @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    repeat (50) @(posedge i_clk);
    #1;
    check("held_valid_pulses", 32'(n_valid), 32'(nv0 + 2));
    check("held_valid_result", last_valid_res, 32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
